// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle control FSM for the 16-bit execution block.
// Fetches one- or two-word instructions, drives opcode/register fields to the
// execution block and sequences writeback, data-memory and I/O phases, jumps,
// CALL/RET through a small return-address stack, and HLT.
//
// Opcode map (op = word0[15:10]):
//   00xxxx  ALU ops (000xxx) and immediate ops (001xxx), flags written in WB
//   001110  LD  (immediate word = address, two-word)
//   001111  ST  (immediate word = address, two-word)
//   010000  MOV       010001  NOP       010010  CALL      010011  RET
//   010100  HLT       010110  IN        010111  OUT
//   011001..011011  shifts (flags written in WB)
//   011000  JMP       011100 JV  011101 JNV  011110 JZ  011111 JNZ
//   anything else behaves as NOP
module exec_sequencer #(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_PC    = 0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] im_addr,
  output logic            im_req,
  input  logic [15:0]     im_data,
  input  logic            im_ack,
  output logic [5:0]      op_dec,
  output logic [2:0]      rd_addr,
  output logic [2:0]      rs_addr,
  output logic [15:0]     ex_data_in,
  input  logic [1:0]      flag_ex,
  output logic            rf_we,
  output logic            dm_re,
  output logic            dm_we,
  input  logic            in_valid,
  input  logic [15:0]     in_data,
  output logic            in_ack,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            halted,
  output logic            fault
);

  // Stack pointer counts occupied entries, 0..STACK_DEPTH inclusive.
  localparam int SP_W = $clog2(STACK_DEPTH) + 1;

  localparam logic [5:0] OP_LD   = 6'b001110;
  localparam logic [5:0] OP_ST   = 6'b001111;
  localparam logic [5:0] OP_MOV  = 6'b010000;
  localparam logic [5:0] OP_NOP  = 6'b010001;
  localparam logic [5:0] OP_CALL = 6'b010010;
  localparam logic [5:0] OP_RET  = 6'b010011;
  localparam logic [5:0] OP_HLT  = 6'b010100;
  localparam logic [5:0] OP_IN   = 6'b010110;
  localparam logic [5:0] OP_OUT  = 6'b010111;
  localparam logic [5:0] OP_JMP  = 6'b011000;

  typedef enum logic [2:0] {
    S_FETCH,
    S_FETCH_IMM,
    S_EXEC,
    S_WB,
    S_MEM,
    S_IN_WAIT,
    S_OUT_WAIT,
    S_HALT
  } state_t;

  state_t            state_reg, state_next;
  logic [PC_W-1:0]   pc_reg, pc_next;
  logic [15:4]       ir_reg, ir_next;   // low nibble of word0 carries nothing
  logic [15:0]       imm_reg, imm_next;
  logic [1:0]        flags_reg, flags_next;
  logic [SP_W-1:0]   sp_reg, sp_next;
  logic              fault_reg, fault_next;
  logic              push_en;
  logic [SP_W-1:0]   sp_dec;
  logic [PC_W-1:0]   target;
  logic [5:0]        ir_op;
  logic              jump_taken;
  logic [PC_W-1:0]   stack_mem [STACK_DEPTH];
  logic              unused_bits;

  assign unused_bits = ^im_data[3:0];

  assign ir_op   = ir_reg[15:10];
  assign rd_addr = ir_reg[9:7];
  assign rs_addr = ir_reg[6:4];
  assign im_addr = pc_reg;
  assign fault   = fault_reg;
  assign sp_dec  = sp_reg - SP_W'(1);
  assign target  = imm_reg[PC_W-1:0];

  function automatic logic is_two_word(input logic [5:0] op);
    return (op[5:3] == 3'b001) || (op == OP_JMP) ||
           (op[5:2] == 4'b0111) || (op == OP_CALL);
  endfunction

  // Conditional jump predicate from the latched flags; op[1:0] picks the test.
  always_comb begin
    jump_taken = 1'b0;
    case (ir_op[1:0])
      2'b00: jump_taken = flags_reg[0];
      2'b01: jump_taken = !flags_reg[0];
      2'b10: jump_taken = flags_reg[1];
      2'b11: jump_taken = !flags_reg[1];
      default: jump_taken = 1'b0;
    endcase
  end

  // Architectural state register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_FETCH;
      pc_reg    <= PC_W'(RESET_PC);
      ir_reg    <= '0;
      imm_reg   <= '0;
      flags_reg <= '0;
      sp_reg    <= '0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      imm_reg   <= imm_next;
      flags_reg <= flags_next;
      sp_reg    <= sp_next;
      fault_reg <= fault_next;
    end
  end

  // Return-address stack storage; pushes only happen from EXEC of a CALL.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[sp_reg[SP_W-2:0]] <= pc_reg;
    end
  end

  // Next-state and output decode for every sequencer state.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    imm_next   = imm_reg;
    flags_next = flags_reg;
    sp_next    = sp_reg;
    fault_next = fault_reg;
    push_en    = 1'b0;
    im_req     = 1'b0;
    op_dec     = OP_NOP;
    ex_data_in = imm_reg;
    rf_we      = 1'b0;
    dm_re      = 1'b0;
    dm_we      = 1'b0;
    in_ack     = 1'b0;
    out_valid  = 1'b0;
    halted     = 1'b0;

    case (state_reg)
      S_FETCH: begin
        im_req = 1'b1;
        if (im_ack) begin
          ir_next    = im_data[15:4];
          pc_next    = pc_reg + PC_W'(1);
          state_next = is_two_word(im_data[15:10]) ? S_FETCH_IMM : S_EXEC;
        end
      end

      S_FETCH_IMM: begin
        im_req = 1'b1;
        if (im_ack) begin
          imm_next   = im_data;
          pc_next    = pc_reg + PC_W'(1);
          state_next = S_EXEC;
        end
      end

      S_EXEC: begin
        op_dec     = ir_op;
        state_next = S_FETCH;
        casez (ir_op)
          OP_LD, OP_ST:                      state_next = S_MEM;
          6'b00????:                         state_next = S_WB;
          OP_MOV, 6'b011001, 6'b011010,
          6'b011011:                         state_next = S_WB;
          OP_IN:                             state_next = S_IN_WAIT;
          OP_OUT:                            state_next = S_OUT_WAIT;
          OP_JMP:                            pc_next = target;
          6'b0111??: begin
            if (jump_taken) begin
              pc_next = target;
            end
          end
          OP_CALL: begin
            if (sp_reg == SP_W'(STACK_DEPTH)) begin
              fault_next = 1'b1;
              state_next = S_HALT;
            end else begin
              push_en = 1'b1;
              sp_next = sp_reg + SP_W'(1);
              pc_next = target;
            end
          end
          OP_RET: begin
            if (sp_reg == '0) begin
              fault_next = 1'b1;
              state_next = S_HALT;
            end else begin
              pc_next = stack_mem[sp_dec[SP_W-2:0]];
              sp_next = sp_dec;
            end
          end
          OP_HLT:                            state_next = S_HALT;
          default:                           state_next = S_FETCH;
        endcase
      end

      S_WB: begin
        rf_we = 1'b1;
        if ((ir_op[5:4] == 2'b00) || (ir_op[5:2] == 4'b0110)) begin
          flags_next = flag_ex;
        end
        state_next = S_FETCH;
      end

      S_MEM: begin
        if (ir_op == OP_LD) begin
          dm_re      = 1'b1;
          state_next = S_WB;
        end else begin
          dm_we      = 1'b1;
          state_next = S_FETCH;
        end
      end

      S_IN_WAIT: begin
        op_dec     = OP_IN;
        ex_data_in = in_data;
        if (in_valid) begin
          in_ack     = 1'b1;
          state_next = S_WB;
        end
      end

      S_OUT_WAIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = S_FETCH;
        end
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: state_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: scoreboard bench for exec_sequencer. Expected fetch
// addresses and strobe events are queued when each program is loaded and
// popped as the DUT produces them; cycle-level timing is checked directly.
module tb_exec_sequencer;

  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_MVI  = 6'b001000;
  localparam logic [5:0] OP_LD   = 6'b001110;
  localparam logic [5:0] OP_ST   = 6'b001111;
  localparam logic [5:0] OP_NOP  = 6'b010001;
  localparam logic [5:0] OP_CALL = 6'b010010;
  localparam logic [5:0] OP_RET  = 6'b010011;
  localparam logic [5:0] OP_HLT  = 6'b010100;
  localparam logic [5:0] OP_IN   = 6'b010110;
  localparam logic [5:0] OP_OUT  = 6'b010111;
  localparam logic [5:0] OP_JMP  = 6'b011000;
  localparam logic [5:0] OP_JV   = 6'b011100;
  localparam logic [5:0] OP_JNV  = 6'b011101;
  localparam logic [5:0] OP_JZ   = 6'b011110;
  localparam logic [5:0] OP_JNZ  = 6'b011111;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  im_addr;
  logic        im_req;
  logic [15:0] im_data;
  logic        im_ack;
  logic [5:0]  op_dec;
  logic [2:0]  rd_addr;
  logic [2:0]  rs_addr;
  logic [15:0] ex_data_in;
  logic [1:0]  flag_ex;
  logic        rf_we;
  logic        dm_re;
  logic        dm_we;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ack;
  logic        out_valid;
  logic        out_ready;
  logic        halted;
  logic        fault;

  logic [15:0] prog [0:255];
  assign im_data = prog[im_addr];

  always #5 clk = ~clk;

  exec_sequencer #(.PC_W(8), .STACK_DEPTH(4), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset),
    .im_addr(im_addr), .im_req(im_req), .im_data(im_data), .im_ack(im_ack),
    .op_dec(op_dec), .rd_addr(rd_addr), .rs_addr(rs_addr),
    .ex_data_in(ex_data_in), .flag_ex(flag_ex),
    .rf_we(rf_we), .dm_re(dm_re), .dm_we(dm_we),
    .in_valid(in_valid), .in_data(in_data), .in_ack(in_ack),
    .out_valid(out_valid), .out_ready(out_ready),
    .halted(halted), .fault(fault)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [19:0] sb_q[$];
  logic mon_en;
  int cyc, halt_cyc, rf_cyc, in_cnt, ack_cnt, ack_cyc, out_cnt;
  logic [15:0] ack_data, mvi_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic logic [15:0] iw(input logic [5:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs);
    return {op, rd, rs, 4'h0};
  endfunction

  task automatic exp_f(input logic [7:0] a);  sb_q.push_back({4'h1, 8'h0, a}); endtask
  task automatic exp_rf(input logic [2:0] r); sb_q.push_back({4'h2, 13'h0, r}); endtask
  task automatic exp_rd();                    sb_q.push_back({4'h3, 16'h0}); endtask
  task automatic exp_wr();                    sb_q.push_back({4'h4, 16'h0}); endtask

  task automatic post(input logic [19:0] ev);
    logic [19:0] e;
    if (sb_q.size() == 0) begin
      chk("sb_extra", ev, 32'h0);
    end else begin
      e = sb_q.pop_front();
      chk("sb_event", ev, e);
    end
  endtask

  // One clock: sample on the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (mon_en) begin
      cyc++;
      if (im_req && im_ack) post({4'h1, 8'h0, im_addr});
      if (rf_we) begin post({4'h2, 13'h0, rd_addr}); rf_cyc = cyc; end
      if (dm_re) post({4'h3, 16'h0});
      if (dm_we) post({4'h4, 16'h0});
      if (op_dec == OP_IN) in_cnt++;
      if (in_ack) begin ack_cnt++; ack_cyc = cyc; ack_data = ex_data_in; end
      if (out_valid) out_cnt++;
      if (op_dec == OP_MVI) mvi_data = ex_data_in;
      if (halted && halt_cyc == 0) halt_cyc = cyc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    reset = 1'b0; im_ack = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = 16'h0; flag_ex = 2'b00; mon_en = 1'b0;
    for (int i = 0; i < 256; i++) prog[i] = iw(OP_NOP, 3'd0, 3'd0);
    sb_q.delete();
    cyc = 0; halt_cyc = 0; rf_cyc = 0; in_cnt = 0; ack_cnt = 0; ack_cyc = 0;
    out_cnt = 0; ack_data = 16'h0; mvi_data = 16'h0;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    reset = 1'b1;
    mon_en = 1'b1;
    cyc = 0;
  endtask

  task automatic run(input int maxc);
    for (int i = 0; i < maxc && !halted; i++) tick();
    chk("halted", {31'h0, halted}, 32'h1);
    repeat (3) tick();
    chk("sb_drain", sb_q.size(), 32'h0);
  endtask

  logic [5:0] jt_op   [7];
  logic [1:0] jt_flag [7];
  logic       jt_take [7];

  initial begin
    jt_op   = '{OP_JZ, OP_JZ, OP_JNZ, OP_JNZ, OP_JV, OP_JNV, OP_JMP};
    jt_flag = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 2'b01, 2'b00};
    jt_take = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset state plus MVI r1,0x1234 / HLT
    start();
    #1;
    chk("rst_strobes", {rf_we, dm_re, dm_we, in_ack, out_valid, halted, fault}, 32'h0);
    chk("rst_opdec", op_dec, OP_NOP);
    prog[0] = iw(OP_MVI, 3'd1, 3'd0); prog[1] = 16'h1234; prog[2] = iw(OP_HLT, 3'd0, 3'd0);
    exp_f(8'h00); exp_f(8'h01); exp_rf(3'd1); exp_f(8'h02);
    release_rst();
    chk("first_req", {im_req, im_addr}, {23'h0, 1'b1, 8'h00});
    run(30);
    chk("mvi_wb_cyc", rf_cyc, 4);
    chk("mvi_imm", mvi_data, 16'h1234);
    chk("hlt_cyc", halt_cyc, 7);
    chk("no_fault", {31'h0, fault}, 32'h0);

    // Conditional / unconditional jumps on latched flags
    for (int t = 0; t < 7; t++) begin
      start();
      prog[0] = iw(OP_SUB, 3'd2, 3'd3); prog[1] = iw(jt_op[t], 3'd0, 3'd0);
      prog[2] = 16'h0020; prog[3] = iw(OP_HLT, 3'd0, 3'd0); prog[8'h20] = iw(OP_HLT, 3'd0, 3'd0);
      flag_ex = jt_flag[t];
      exp_f(8'h00); exp_rf(3'd2); exp_f(8'h01); exp_f(8'h02);
      exp_f(jt_take[t] ? 8'h20 : 8'h03);
      release_rst();
      repeat (3) tick();
      flag_ex = ~jt_flag[t];
      run(30);
      chk("jmp_hlt_cyc", halt_cyc, 9);
    end

    // Four nested CALLs then four RETs
    start();
    prog[8'h00] = iw(OP_CALL, 0, 0); prog[8'h01] = 16'h0010; prog[8'h02] = iw(OP_HLT, 0, 0);
    prog[8'h10] = iw(OP_CALL, 0, 0); prog[8'h11] = 16'h0020; prog[8'h12] = iw(OP_RET, 0, 0);
    prog[8'h20] = iw(OP_CALL, 0, 0); prog[8'h21] = 16'h0030; prog[8'h22] = iw(OP_RET, 0, 0);
    prog[8'h30] = iw(OP_CALL, 0, 0); prog[8'h31] = 16'h0040; prog[8'h32] = iw(OP_RET, 0, 0);
    prog[8'h40] = iw(OP_RET, 0, 0);
    exp_f(8'h00); exp_f(8'h01); exp_f(8'h10); exp_f(8'h11); exp_f(8'h20); exp_f(8'h21);
    exp_f(8'h30); exp_f(8'h31); exp_f(8'h40); exp_f(8'h32); exp_f(8'h22); exp_f(8'h12);
    exp_f(8'h02);
    release_rst();
    run(80);
    chk("call4_fault", {31'h0, fault}, 32'h0);

    // Fifth nested CALL overflows the stack
    start();
    prog[8'h00] = iw(OP_CALL, 0, 0); prog[8'h01] = 16'h0010;
    prog[8'h10] = iw(OP_CALL, 0, 0); prog[8'h11] = 16'h0020;
    prog[8'h20] = iw(OP_CALL, 0, 0); prog[8'h21] = 16'h0030;
    prog[8'h30] = iw(OP_CALL, 0, 0); prog[8'h31] = 16'h0040;
    prog[8'h40] = iw(OP_CALL, 0, 0); prog[8'h41] = 16'h0050;
    exp_f(8'h00); exp_f(8'h01); exp_f(8'h10); exp_f(8'h11); exp_f(8'h20); exp_f(8'h21);
    exp_f(8'h30); exp_f(8'h31); exp_f(8'h40); exp_f(8'h41);
    release_rst();
    run(80);
    chk("call5_fault", {31'h0, fault}, 32'h1);
    chk("call5_pc", im_addr, 8'h42);

    // RET with an empty stack
    start();
    prog[0] = iw(OP_RET, 0, 0);
    exp_f(8'h00);
    release_rst();
    run(20);
    chk("ret_empty_fault", {31'h0, fault}, 32'h1);

    // IN with late in_valid, OUT with out_ready low for two cycles
    start();
    prog[0] = iw(OP_IN, 3'd4, 0); prog[1] = iw(OP_OUT, 0, 3'd4); prog[2] = iw(OP_HLT, 0, 0);
    in_data = 16'hBEEF;
    exp_f(8'h00); exp_rf(3'd4); exp_f(8'h01); exp_f(8'h02);
    release_rst();
    repeat (4) tick();
    in_valid = 1'b1;
    repeat (6) tick();
    out_ready = 1'b1;
    run(20);
    chk("in_opdec_cnt", in_cnt, 4);
    chk("in_ack_cnt", ack_cnt, 1);
    chk("in_ack_cyc", ack_cyc, 5);
    chk("in_data_fwd", ack_data, 16'hBEEF);
    chk("in_wb_cyc", rf_cyc, 6);
    chk("out_valid_cnt", out_cnt, 3);
    chk("io_hlt_cyc", halt_cyc, 14);

    // Reset while stalled in FETCH_IMM aborts the instruction
    start();
    prog[0] = iw(OP_MVI, 3'd1, 0); prog[1] = 16'h5678; prog[2] = iw(OP_HLT, 0, 0);
    exp_f(8'h00);
    release_rst();
    tick();
    im_ack = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("abort_pc", im_addr, 8'h00);
    chk("abort_strb", {rf_we, dm_we, dm_re}, 32'h0);
    repeat (2) tick();
    chk("abort_sb", sb_q.size(), 32'h0);
    exp_f(8'h00); exp_f(8'h01); exp_rf(3'd1); exp_f(8'h02);
    im_ack = 1'b1;
    reset = 1'b1;
    run(30);
    chk("abort_imm", mvi_data, 16'h5678);

    // LD then ST then HLT: latency 5 and 4
    start();
    prog[0] = iw(OP_LD, 3'd5, 0); prog[1] = 16'h0040;
    prog[2] = iw(OP_ST, 0, 3'd5); prog[3] = 16'h0041; prog[4] = iw(OP_HLT, 0, 0);
    exp_f(8'h00); exp_f(8'h01); exp_rd(); exp_rf(3'd5);
    exp_f(8'h02); exp_f(8'h03); exp_wr(); exp_f(8'h04);
    release_rst();
    run(40);
    chk("ldst_hlt_cyc", halt_cyc, 12);

    // Undefined opcode behaves as NOP
    start();
    prog[0] = iw(6'b111000, 3'd3, 3'd3); prog[1] = iw(OP_HLT, 0, 0);
    exp_f(8'h00); exp_f(8'h01);
    release_rst();
    run(20);
    chk("undef_hlt_cyc", halt_cyc, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
